ps2_rx_fifo: RTL and testbench

//  PS/2 device-to-host receiver with bit-level FSM, frame checking, timeout recovery and a scancode FIFO.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_sync_db.sv | 39 +++
 rtl/ps2_rx_fifo.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types and constants.
// Prefix decode is enabled with PS2_PREFIX_DECODE_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int ENTRY_W = 10;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL = 8'hF0;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_db.sv
// Two-flop synchroniser plus debouncer for one PS/2 pad.
// Idle level after reset is high.
module ps2_sync_db #(
  parameter int DB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl
);

  localparam int CW = $clog2(DB_CYC);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // a new level is adopted after DB_CYC consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b1;
      s2  <= 1'b1;
      lvl <= 1'b1;
      cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame check, timeout and FIFO.
// Optional prefix decode: define PS2_PREFIX_DECODE_EN.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DB_CYC      = 16,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps_clk,
  input  logic               ps_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               irq,
  output logic               frame_err,
  output logic               overflow,
  input  logic               err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic clk_db;
  logic data_db;
  logic clk_dly;
  logic fall;

  ps2_sync_db #(.DB_CYC(DB_CYC)) u_clk_db (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps_clk),
    .lvl   (clk_db)
  );

  ps2_sync_db #(.DB_CYC(DB_CYC)) u_data_db (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (ps_data),
    .lvl   (data_db)
  );

  assign fall = clk_dly & ~clk_db;

  ps2_state_e    state;
  ps2_state_e    state_n;
  logic [7:0]    sh;
  logic [2:0]    bit_cnt;
  logic          par_q;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          frame_end;
  logic          frame_bad;
  logic          frame_good;

  assign to_hit = (state != ST_IDLE) &&
                  (to_cnt == TW'(TIMEOUT_CYC));

  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fall && !data_db) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (fall && bit_cnt == 3'd7) state_n = ST_PARITY;
      end
      ST_PARITY: begin
        if (fall) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (fall) begin
          state_n   = ST_IDLE;
          frame_end = 1'b1;
          frame_bad = !data_db || !odd_ok(sh, par_q);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (to_hit) begin
      state_n   = ST_IDLE;
      frame_end = 1'b0;
      frame_bad = 1'b1;
    end
  end

  assign frame_good = frame_end & ~frame_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_dly <= 1'b1;
      sh      <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      clk_dly <= clk_db;
      to_cnt  <= (fall || state == ST_IDLE) ?
                 '0 : to_cnt + 1'b1;
      if (fall && state == ST_IDLE) bit_cnt <= '0;
      if (fall && state == ST_DATA) begin
        sh      <= {data_db, sh[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == ST_PARITY) par_q <= data_db;
    end
  end

  logic               push_req;
  logic [ENTRY_W-1:0] push_word;

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_q;
  logic rel_q;
  logic is_pfx;

  assign is_pfx    = (sh == PS2_PFX_EXT) ||
                     (sh == PS2_PFX_REL);
  assign push_req  = frame_good && !is_pfx;
  assign push_word = {ext_q, rel_q, sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (frame_bad) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (frame_good) begin
      if (sh == PS2_PFX_EXT) begin
        ext_q <= 1'b1;
      end else if (sh == PS2_PFX_REL) begin
        rel_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end
`else
  assign push_req  = frame_good;
  assign push_word = {2'b00, sh};
`endif

  logic               push_pend;
  logic [ENTRY_W-1:0] push_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_pend  <= 1'b0;
      push_entry <= '0;
    end else begin
      push_pend <= push_req;
      if (push_req) push_entry <= push_word;
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [ENTRY_W-1:0] last_q;
  logic               full;
  logic               do_pop;
  logic               do_push;
  logic               drop;

  assign rd_valid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign do_pop   = rd_valid & rd_ready;
  // a pop in the same cycle frees the slot for a push into a full FIFO
  assign do_push  = push_pend & (~full | do_pop);
  assign drop     = push_pend & full & ~do_pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq       <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      irq <= rd_valid;
      if (frame_bad)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo.
// Honours PS2_PREFIX_DECODE_EN when defined.
module tb_ps2_rx_fifo;

  localparam int DB    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ps_clk   = 1'b1;
  logic       ps_data  = 1'b1;
  logic       rd_ready = 1'b0;
  logic       err_clr  = 1'b0;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic       irq;
  logic       frame_err;
  logic       overflow;

  int         errors    = 0;
  int         checks    = 0;
  int         meas_k    = 0;
  bit         measuring = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .DB_CYC      (DB),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps_clk    (ps_clk),
    .ps_data   (ps_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .irq       (irq),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_clr   (err_clr)
  );

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %03h want none",
                 rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_data !== mon_e) begin
          errors++;
          $display("FAIL pop_data: got %03h want %03h",
                   rd_data, mon_e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic ps_bit(input logic b, input int pop_k);
    ps_data = b;
    cyc(6);
    ps_clk = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (k == pop_k - 1) rd_ready = 1'b1;
      if (k == pop_k)     rd_ready = 1'b0;
      if (measuring && meas_k == 0 && rd_valid)
        meas_k = k;
    end
    ps_clk = 1'b1;
    cyc(6);
  endtask

  task automatic glitch();
    ps_clk = 1'b0;
    cyc(DB - 2);
    ps_clk = 1'b1;
    cyc(6);
  endtask

  task automatic send_frame(
    input logic [7:0] d,
    input logic       bad_par,
    input int         pop_k,
    input int         glitch_at
  );
    ps_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_at) glitch();
      ps_bit(d[i], 0);
    end
    ps_bit(par_of(d) ^ bad_par, 0);
    ps_bit(1'b1, pop_k);
  endtask

  task automatic partial(input int nbits);
    ps_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) ps_bit(1'b1, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    rd_ready = 1'b1;
    while ((exp_q.size() != 0 || rd_valid) && t < 300) begin
      cyc(1);
      t++;
    end
    rd_ready = 1'b0;
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("rst_valid", rd_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", rd_data, 0);

    measuring = 1'b1;
    send_frame(8'h1C, 1'b0, 0, -1);
    measuring = 1'b0;
    cyc(4);
    chk("t1_valid", rd_valid, 1);
    chk("t1_data", rd_data, 10'h01C);
    chk("t1_irq", irq, 1);
    chk("t1_latency", meas_k, DB + 4);
    exp_q.push_back(10'h01C);
    drain("t1_drain");
    chk("t1_empty", rd_valid, 0);
    cyc(2);
    chk("t1_irq_low", irq, 0);
    chk("t1_hold", rd_data, 10'h01C);

    send_frame(8'h1C, 1'b1, 0, -1);
    cyc(10);
    chk("t2_nopush", rd_valid, 0);
    chk("t2_ferr", frame_err, 1);
    pulse_clr();
    chk("t2_clr", frame_err, 0);

    partial(4);
    cyc(2 * TO);
    chk("t3_timeout", frame_err, 1);
    chk("t3_nopush", rd_valid, 0);
    pulse_clr();
    exp_q.push_back(10'h02A);
    send_frame(8'h2A, 1'b0, 0, -1);
    drain("t3_drain");
    chk("t3_ferr", frame_err, 0);

    for (int i = 1; i <= DEPTH + 1; i++) begin
      logic [7:0] b;
      b = 8'(i * 8'h11);
      if (i <= DEPTH) exp_q.push_back({2'b00, b});
      send_frame(b, 1'b0, 0, -1);
    end
    cyc(10);
    chk("t4_ovf", overflow, 1);
    chk("t4_irq", irq, 1);
    pulse_clr();
    chk("t4_ovf_clr", overflow, 0);
    exp_q.push_back(10'h066);
    send_frame(8'h66, 1'b0, meas_k, -1);
    cyc(4);
    chk("t4_popush", overflow, 0);
    drain("t4_drain");

`ifdef PS2_PREFIX_DECODE_EN
    exp_q.push_back(10'h374);
`else
    exp_q.push_back(10'h0E0);
    exp_q.push_back(10'h0F0);
    exp_q.push_back(10'h074);
`endif
    send_frame(8'hE0, 1'b0, 0, -1);
    send_frame(8'hF0, 1'b0, 0, -1);
    send_frame(8'h74, 1'b0, 0, -1);
    cyc(10);
    drain("t5_drain");

    exp_q.push_back(10'h05A);
    send_frame(8'h5A, 1'b0, 0, 4);
    cyc(10);
    drain("t6_glitch");
    chk("t6_gl_ferr", frame_err, 0);

    send_frame(8'h1C, 1'b1, 0, -1);
    exp_q.push_back(10'h033);
    send_frame(8'h33, 1'b0, 0, -1);
    cyc(4);
    chk("t6_pre_valid", rd_valid, 1);
    partial(3);
    #3;
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_irq", irq, 0);
    chk("t6_rst_data", rd_data, 0);
    chk("t6_rst_ferr", frame_err, 0);
    chk("t6_rst_ovf", overflow, 0);
    exp_q.delete();
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 0, -1);
    cyc(10);
    drain("t6_resync");
    chk("t6_ferr", frame_err, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
